// File: rtl/mux_gamma_scheduler.sv
// Round-robin gamma-window scheduler sharing one column between two spike networks.
// Optional MUX_SCHED_EARLY_TERM_EN ends a window right after the first tick that carries a spike.
module mux_gamma_scheduler #(
  parameter int Q         = 2,
  parameter int GAMMA_LEN = 16,
  localparam int TW       = $clog2(GAMMA_LEN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  output logic [1:0]      grant,
  output logic            net_sel,
  output logic            col_grst,
  output logic            busy,
  input  logic [Q-1:0]    col_spikes,
  output logic [Q-1:0]    spikes1_out,
  output logic [Q-1:0]    spikes2_out,
  output logic [Q*TW-1:0] stime1,
  output logic [Q*TW-1:0] stime2,
  output logic [1:0]      done
);

  typedef enum logic [1:0] {S_IDLE, S_GRST, S_RUN, S_DONE} state_t;

  localparam logic [TW-1:0] NO_SPIKE = TW'(GAMMA_LEN);
  localparam logic [TW-1:0] LAST_TICK = TW'(GAMMA_LEN - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_grant;
  logic [1:0]      w_grant_nxt;
  logic            r_last;
  logic [TW-1:0]   r_tick;
  logic [Q-1:0]    r_acc;
  logic [Q*TW-1:0] r_stime;
  logic [Q-1:0]    r_spk1;
  logic [Q-1:0]    r_spk2;
  logic [Q*TW-1:0] r_st1;
  logic [Q*TW-1:0] r_st2;
  logic [Q-1:0]    w_acc_nxt;
  logic [Q*TW-1:0] w_stime_nxt;
  logic            w_owner;
  logic            w_other;
  logic            w_idle_pick;
  logic            w_early_hit;
  logic            w_win_end;

  assign w_owner     = r_grant[1];
  assign w_other     = ~r_grant[1];
  // On a tie the net that was not served last wins.
  assign w_idle_pick = (req == 2'b11) ? ~r_last : req[1];

`ifdef MUX_SCHED_EARLY_TERM_EN
  assign w_early_hit = |col_spikes;
`else
  assign w_early_hit = 1'b0;
`endif

  assign w_win_end = (r_state == S_RUN) && ((r_tick == LAST_TICK) || w_early_hit);

  always_comb begin
    w_acc_nxt   = r_acc | col_spikes;
    w_stime_nxt = r_stime;
    for (int i = 0; i < Q; i++) begin
      if (col_spikes[i] && !r_acc[i]) w_stime_nxt[i*TW +: TW] = r_tick;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    col_grst    = 1'b0;
    busy        = 1'b1;
    done        = 2'b00;
    case (r_state)
      S_IDLE: begin
        col_grst = 1'b1;
        busy     = 1'b0;
        if (|req) begin
          w_state_nxt = S_GRST;
          w_grant_nxt = w_idle_pick ? 2'b10 : 2'b01;
        end
      end
      S_GRST: begin
        col_grst    = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_win_end) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done = r_grant;
        // The served net's request is stale here; only the other net can chain a window.
        if (req[w_other]) begin
          w_state_nxt = S_GRST;
          w_grant_nxt = w_other ? 2'b10 : 2'b01;
        end else begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = 2'b00;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant <= 2'b00;
      r_last  <= 1'b1;
      r_tick  <= '0;
    end else begin
      r_grant <= w_grant_nxt;
      if (r_state == S_DONE) r_last <= w_owner;
      if (r_state == S_GRST)     r_tick <= '0;
      else if (r_state == S_RUN) r_tick <= r_tick + TW'(1);
    end
  end

  // Window accumulators, committed to the owner's result registers as RUN ends.
  always_ff @(posedge clk) begin
    if (r_state == S_GRST) begin
      r_acc   <= '0;
      r_stime <= {Q{NO_SPIKE}};
    end else if (r_state == S_RUN) begin
      r_acc   <= w_acc_nxt;
      r_stime <= w_stime_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_spk1 <= '0;
      r_spk2 <= '0;
      r_st1  <= {Q{NO_SPIKE}};
      r_st2  <= {Q{NO_SPIKE}};
    end else if (w_win_end) begin
      if (w_owner) begin
        r_spk2 <= w_acc_nxt;
        r_st2  <= w_stime_nxt;
      end else begin
        r_spk1 <= w_acc_nxt;
        r_st1  <= w_stime_nxt;
      end
    end
  end

  assign grant       = r_grant;
  assign net_sel     = r_grant[1];
  assign spikes1_out = r_spk1;
  assign spikes2_out = r_spk2;
  assign stime1      = r_st1;
  assign stime2      = r_st2;

endmodule

// File: tb/tb_mux_gamma_scheduler.sv
// Bench for mux_gamma_scheduler: window-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mux_gamma_scheduler;
  localparam int Q  = 2;
  localparam int G  = 16;
  localparam int TW = $clog2(G + 1);
`ifdef MUX_SCHED_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      req = 2'b00;
  logic [Q-1:0]    col_spikes = '0;
  logic [1:0]      grant;
  logic            net_sel;
  logic            col_grst;
  logic            busy;
  logic [Q-1:0]    spikes1_out;
  logic [Q-1:0]    spikes2_out;
  logic [Q*TW-1:0] stime1;
  logic [Q*TW-1:0] stime2;
  logic [1:0]      done;

  mux_gamma_scheduler #(.Q(Q), .GAMMA_LEN(G)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .net_sel(net_sel),
    .col_grst(col_grst), .busy(busy), .col_spikes(col_spikes),
    .spikes1_out(spikes1_out), .spikes2_out(spikes2_out),
    .stime1(stime1), .stime2(stime2), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int base   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  function automatic logic [Q*TW-1:0] st2(input int s1, input int s0);
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    a = TW'(s1);
    b = TW'(s0);
    return {a, b};
  endfunction

  // Reference model: a window is GRST (offset 0), then ticks recorded until the end
  // condition, then one DONE cycle; results are derived from the recorded tick history.
  bit           m_valid = 0;
  bit           m_busy, m_done, m_owner, m_last;
  int           m_off;
  logic [Q-1:0] m_rec [G];
  logic [Q-1:0] m_sp  [2];
  int           m_st  [2][Q];

  task automatic m_reset();
    m_busy = 0; m_done = 0; m_last = 1; m_owner = 0; m_off = 0;
    for (int n = 0; n < 2; n++) begin
      m_sp[n] = '0;
      for (int i = 0; i < Q; i++) m_st[n][i] = G;
    end
  endtask

  task automatic m_finish_window(input int last_t);
    m_sp[m_owner] = '0;
    for (int i = 0; i < Q; i++) begin
      m_st[m_owner][i] = G;
      for (int t = last_t; t >= 0; t--) begin
        if (m_rec[t][i]) begin
          m_sp[m_owner][i] = 1'b1;
          m_st[m_owner][i] = t;
        end
      end
    end
  endtask

  task automatic m_step();
    int t;
    if (rst) begin
      m_valid = 1;
      m_reset();
    end else if (m_valid) begin
      if (!m_busy) begin
        if (req != 2'b00) begin
          m_owner = (req == 2'b11) ? !m_last : req[1];
          m_busy = 1; m_off = 0; m_done = 0;
        end
      end else if (m_done) begin
        m_last = m_owner;
        m_done = 0;
        if (req[!m_owner]) begin
          m_owner = !m_owner;
          m_off = 0;
        end else begin
          m_busy = 0;
        end
      end else if (m_off == 0) begin
        for (int k = 0; k < G; k++) m_rec[k] = '0;
        m_off = 1;
      end else begin
        t = m_off - 1;
        m_rec[t] = col_spikes;
        if (t == G - 1 || (EARLY && col_spikes != '0)) begin
          m_finish_window(t);
          m_done = 1;
        end else begin
          m_off++;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    m_step();
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    logic [1:0] e_grant;
    @(negedge clk);
    if (m_valid) begin
      e_grant = m_busy ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      chk("m_grant", grant, e_grant);
      chk("m_net_sel", net_sel, e_grant[1]);
      chk("m_col_grst", col_grst, !m_busy || (m_off == 0 && !m_done));
      chk("m_busy", busy, m_busy);
      chk("m_done", done, m_done ? e_grant : 2'b00);
      chk("m_spikes1", spikes1_out, m_sp[0]);
      chk("m_spikes2", spikes2_out, m_sp[1]);
      chk("m_stime1", stime1, st2(m_st[0][1], m_st[0][0]));
      chk("m_stime2", stime2, st2(m_st[1][1], m_st[1][0]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic go(input int n);
    while (cyc < base + n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; req = 2'b00; col_spikes = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    base = cyc;
  endtask

  initial begin
    // Scenario 1: single net0 window, spike on neuron1 at tick 5.
    do_reset();
    req = 2'b01;
    chk("s1_rst_grant", grant, 2'b00);
    chk("s1_rst_grst", col_grst, 1'b1);
    chk("s1_rst_busy", busy, 1'b0);
    chk("s1_rst_stime1", stime1, st2(16, 16));
    go(1);
    chk("s1_grant_c1", grant, 2'b01);
    chk("s1_grst_c1", col_grst, 1'b1);
    go(2);
    chk("s1_grst_c2", col_grst, 1'b0);
    go(7);  col_spikes = 2'b10;
    go(8);  col_spikes = 2'b00;
    go(18);
`ifndef MUX_SCHED_EARLY_TERM_EN
    chk("s1_done", done, 2'b01);
    chk("s1_spikes1", spikes1_out, 2'b10);
    chk("s1_stime1", stime1, st2(5, 16));
    chk("s1_spikes2", spikes2_out, 2'b00);
    chk("s1_stime2", stime2, st2(16, 16));
`endif
    req = 2'b00;
    go(19);
    chk("s1_idle_grant", grant, 2'b00);

    // Scenario 2: simultaneous requests after reset, net0 first, then net1 back-to-back.
    do_reset();
    req = 2'b11;
    go(1);  chk("s2_grant_c1", grant, 2'b01);
    go(18); chk("s2_done0", done, 2'b01);
    req = 2'b10;
    go(19);
    chk("s2_grant_c19", grant, 2'b10);
    chk("s2_net_sel", net_sel, 1'b1);
    chk("s2_grst_c19", col_grst, 1'b1);
    go(36); chk("s2_done1", done, 2'b10);
    req = 2'b00;
    go(38);

    // Scenario 3: both held for four windows; last served was net1.
    base = cyc;
    req = 2'b11;
    go(1);  chk("s3_w0", grant, 2'b01);
    go(19); chk("s3_w1", grant, 2'b10);
    go(37); chk("s3_w2", grant, 2'b01);
    go(54); chk("s3_done2", done, 2'b01);
    go(55); chk("s3_w3", grant, 2'b10);
    go(72); chk("s3_done3", done, 2'b10);
    req = 2'b00;
    go(74);

    // Scenario 4: complete net1 window, then reset at tick 7 of the next one.
    do_reset();
    req = 2'b10;
    go(6);  col_spikes = 2'b01;
    go(7);  col_spikes = 2'b00;
    go(18);
`ifndef MUX_SCHED_EARLY_TERM_EN
    chk("s4_spikes2", spikes2_out, 2'b01);
    chk("s4_stime2", stime2, st2(16, 4));
    chk("s4_stime1", stime1, st2(16, 16));
`endif
    req = 2'b00;
    go(20); req = 2'b10;
    go(29);
`ifndef MUX_SCHED_EARLY_TERM_EN
    chk("s4_busy_mid", busy, 1'b1);
`endif
    rst = 1;
    go(30);
    rst = 0; req = 2'b00;
    chk("s4_rst_grant", grant, 2'b00);
    chk("s4_rst_grst", col_grst, 1'b1);
    chk("s4_rst_busy", busy, 1'b0);
    chk("s4_rst_done", done, 2'b00);
    chk("s4_rst_spikes2", spikes2_out, 2'b00);
    chk("s4_rst_stime2", stime2, st2(16, 16));

    // Scenario 5: spikes outside RUN ignored, repeats keep first tick, last tick captured.
    do_reset();
    req = 2'b01; col_spikes = 2'b11;
    go(2);  col_spikes = 2'b00;
    go(4);  col_spikes = 2'b01;
    go(5);  col_spikes = 2'b00;
    go(11); col_spikes = 2'b01;
    go(12); col_spikes = 2'b00;
    go(17); col_spikes = 2'b10;
    go(18);
    col_spikes = 2'b11;
`ifndef MUX_SCHED_EARLY_TERM_EN
    chk("s5_spikes1", spikes1_out, 2'b11);
    chk("s5_stime1", stime1, st2(15, 2));
`endif
    req = 2'b00;
    go(21); col_spikes = 2'b00;
`ifndef MUX_SCHED_EARLY_TERM_EN
    chk("s5_hold_stime1", stime1, st2(15, 2));
`endif

    // Scenario 6: spike on neuron0 at tick 3; window length depends on early termination.
    do_reset();
    req = 2'b01;
    go(5); col_spikes = 2'b01;
    go(6); col_spikes = 2'b00;
`ifdef MUX_SCHED_EARLY_TERM_EN
    chk("s6_done_early", done, 2'b01);
    chk("s6_stime1_early", stime1, st2(16, 3));
    req = 2'b00;
`else
    chk("s6_no_done_c6", done, 2'b00);
    go(18);
    chk("s6_done_full", done, 2'b01);
    chk("s6_stime1_full", stime1, st2(16, 3));
    req = 2'b00;
`endif
    go(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
